mbc3_rtc: RTL and testbench
===========================

Name: mbc3_rtc

Overview:
- MBC3 real-time clock that sits downstream of the GBC mapper on its RTC Wishbone initiator port.
- Keeps live seconds, minutes, hours and a 9-bit day counter, advanced from the system clock by a prescaler.
- Provides a latched snapshot for reads, accepts writes to live registers, and implements the MBC3 latch sequence: $6000 write 0 then 1.
- Single-cycle registered responses; it never stalls the mapper.

Parameters:
- CLK_HZ, default 8388608, SysCon clock frequency; one RTC second = CLK_HZ clocks.
- PRESCALE_W, default 24, prescaler counter width; must satisfy 2^PRESCALE_W >= CLK_HZ.

Ports:
- CLK  in  1  SysCon clock.
- RST  in  1  synchronous, active-high reset.
- STB  in  1  request strobe from mapper; valid for one cycle.
- WE  in  1  1 = write, 0 = read.
- ADDR  in  3  register index, mapper RAMBankID[2:0]: 0=S, 1=M, 2=H, 3=DL, 4=DH; 5..7 unmapped.
- DAT_ToTarget  in  8  write data.
- DAT_ToInitiator  out  8  read data.
- ACK  out  1  response valid.
- STALL  out  1  tied 0.
- LATCH_STB  in  1  mapper saw a write to $6000-$7FFF.
- LATCH_D  in  1  bit 0 of that write.

Behaviour:
- Reset:
  - Live and latched S/M/H/DL/DH = 0; prescaler = 0; latch-armed flag = 0.
  - ACK = 0; DAT_ToInitiator = 8'hFF.
- Tick: prescaler increments each clock while DH.6 (halt) = 0. On reaching CLK_HZ-1 it returns to 0 and a one-cycle sec_tick fires. While halted, the prescaler holds its value.
- Carry chain on sec_tick:
  - S: 59→0 carries to M. Any value 60..63 increments to 63, then wraps to 0 with no carry.
  - M: same rule as S; a carry goes to H.
  - H: 23→0 carries to day. Any value 24..31 increments to 31, then wraps to 0 with no carry.
  - Day {DH.0, DL} is 9 bits: 511→0 sets DH.7 (carry). DH.7 is sticky and is cleared only by a write.
- Writes (STB & WE):
  - Update the live register at ADDR: S/M are 6 bits, H is 5 bits, DL is 8 bits, DH keeps bits 7, 6 and 0.
  - A write to S also clears the prescaler.
  - A write to an unmapped index is ignored.
  - Write has priority over a same-cycle tick/carry into that register. Other registers still take the carry.
- Reads (STB & !WE):
  - Return the latched register with unused bits forced to 1: S/M {2'b11, v}, H {3'b111, v}, DH {v7, v6, 5'b11111, v0}.
  - Unmapped index returns 8'hFF.
- Response timing:
  - ACK is asserted the cycle after STB, for exactly one cycle, for both reads and writes.
  - DAT_ToInitiator is valid while ACK = 1 and holds its value until the next read.
  - Back-to-back STB on consecutive cycles gives back-to-back ACKs.
- Latch:
  - LATCH_STB with LATCH_D = 0 sets armed.
  - LATCH_STB with LATCH_D = 1 while armed copies live → latched on that edge, using pre-tick values if a tick occurs the same cycle, and clears armed.
  - Any other LATCH_STB value clears armed.
  - Latch and register write in the same cycle: the latch captures the pre-write live value.
- Reset mid-operation: any pending ACK is dropped; state returns to reset values on the next edge.

Optional Feature:
- Macro MBC3_RTC_FAST_TICK_EN.
- Defined: sec_tick fires every 64 clocks, ignoring CLK_HZ, so simulation can cover minute/hour/day rollover quickly.
- Undefined: sec_tick every CLK_HZ clocks as specified above. No port change either way.

Test Plan:
- Reset, then STB read ADDR 0..4, one cycle per read → ACK one cycle later each time; data FF-masked zeros: 8'hC0, C0, E0, 00, 3E.
- FAST_TICK; write S=59, M=59, H=23, DL=FF, DH=01; run 64 clocks; latch (0 then 1); read → S=0, M=0, H=0, DL=0, DH.0=0, DH.7=1 (DH read 8'hBE).
- Write DH=8'h40 (halt); wait 1000 clocks; latch; read S → unchanged value. Clear halt → S advances after 64 clocks.
- Write S=61; tick 3 times → S reads 63, then 0; M unchanged.
- LATCH_D sequence 1, 0, 0, 1 → only the final 1 latches. A latch on the same cycle as a write S=5 captures the old S.
- Write S on the same cycle as sec_tick → S = written value, prescaler restarts from 0, next tick 64 clocks later (FAST_TICK).

Source files
------------

// File: rtl/mbc3_rtc.sv
// MBC3 real-time clock: live S/M/H/day counters, latched read snapshot, Wishbone target port.
// Define MBC3_RTC_FAST_TICK_EN to fire the seconds tick every 64 clocks instead of every CLK_HZ.
module mbc3_rtc #(
  parameter int CLK_HZ     = 8388608,
  parameter int PRESCALE_W = 24
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       STB,
  input  logic       WE,
  input  logic [2:0] ADDR,
  input  logic [7:0] DAT_ToTarget,
  output logic [7:0] DAT_ToInitiator,
  output logic       ACK,
  output logic       STALL,
  input  logic       LATCH_STB,
  input  logic       LATCH_D
);

  localparam logic [2:0] REG_S  = 3'd0;
  localparam logic [2:0] REG_M  = 3'd1;
  localparam logic [2:0] REG_H  = 3'd2;
  localparam logic [2:0] REG_DL = 3'd3;
  localparam logic [2:0] REG_DH = 3'd4;

`ifdef MBC3_RTC_FAST_TICK_EN
  localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(63);
`else
  localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(CLK_HZ - 1);
`endif

  typedef struct packed {
    logic       carry;
    logic       halt;
    logic [8:0] day;
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
  } rtc_t;

  rtc_t                  live;
  rtc_t                  latched;
  rtc_t                  live_next;
  logic [PRESCALE_W-1:0] prescale;
  logic                  armed;
  logic                  sec_tick;
  logic                  wr_en;
  logic                  s_carry;
  logic                  m_carry;
  logic                  h_carry;

  assign STALL    = 1'b0;
  assign wr_en    = STB && WE;
  assign sec_tick = !live.halt && (prescale == TICK_LAST);

  // Carry chain first, then the bus write overrides only the register it targets.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    live_next = live;
    s_carry   = 1'b0;
    m_carry   = 1'b0;
    h_carry   = 1'b0;
    if (sec_tick) begin
      // Out-of-range values count up to all-ones and wrap naturally without carrying.
      s_carry       = (live.sec == 6'd59);
      live_next.sec = s_carry ? 6'd0 : live.sec + 6'd1;
      if (s_carry) begin
        m_carry       = (live.min == 6'd59);
        live_next.min = m_carry ? 6'd0 : live.min + 6'd1;
      end
      if (m_carry) begin
        h_carry      = (live.hr == 5'd23);
        live_next.hr = h_carry ? 5'd0 : live.hr + 5'd1;
      end
      if (h_carry) begin
        live_next.day = live.day + 9'd1;
        if (live.day == 9'd511) live_next.carry = 1'b1;
      end
    end
    if (wr_en) begin
      case (ADDR)
        REG_S:  live_next.sec      = DAT_ToTarget[5:0];
        REG_M:  live_next.min      = DAT_ToTarget[5:0];
        REG_H:  live_next.hr       = DAT_ToTarget[4:0];
        REG_DL: live_next.day[7:0] = DAT_ToTarget;
        REG_DH: begin
          live_next.carry  = DAT_ToTarget[7];
          live_next.halt   = DAT_ToTarget[6];
          live_next.day[8] = DAT_ToTarget[0];
        end
        default: ;
      endcase
    end
  end

  function automatic logic [7:0] read_view(input rtc_t r, input logic [2:0] a);
    case (a)
      REG_S:   return {2'b11, r.sec};
      REG_M:   return {2'b11, r.min};
      REG_H:   return {3'b111, r.hr};
      REG_DL:  return r.day[7:0];
      REG_DH:  return {r.carry, r.halt, 5'b11111, r.day[8]};
      default: return 8'hFF;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      live     <= '0;
      prescale <= '0;
    end else begin
      live <= live_next;
      if (wr_en && ADDR == REG_S) prescale <= '0;
      else if (!live.halt)        prescale <= sec_tick ? '0 : prescale + 1'b1;
    end
  end

  // Latch copies the pre-tick, pre-write live value on the 0 -> 1 sequence.
  always_ff @(posedge CLK) begin
    if (RST) begin
      armed   <= 1'b0;
      latched <= '0;
    end else if (LATCH_STB) begin
      if (!LATCH_D) begin
        armed <= 1'b1;
      end else begin
        if (armed) latched <= live;
        armed <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ACK             <= 1'b0;
      DAT_ToInitiator <= 8'hFF;
    end else begin
      ACK <= STB;
      if (STB && !WE) DAT_ToInitiator <= read_view(latched, ADDR);
    end
  end

endmodule

// File: tb/tb_mbc3_rtc.sv
// Self-checking bench for mbc3_rtc; one RTC second is shortened to 64 clocks via CLK_HZ.
module tb_mbc3_rtc;

  localparam int P = 64;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       STB = 1'b0;
  logic       WE = 1'b0;
  logic [2:0] ADDR = 3'd0;
  logic [7:0] DAT_ToTarget = 8'h00;
  logic [7:0] DAT_ToInitiator;
  logic       ACK;
  logic       STALL;
  logic       LATCH_STB = 1'b0;
  logic       LATCH_D = 1'b0;

  int checks = 0;
  int errors = 0;

  mbc3_rtc #(.CLK_HZ(P), .PRESCALE_W(7)) dut (
    .CLK(CLK), .RST(RST), .STB(STB), .WE(WE), .ADDR(ADDR),
    .DAT_ToTarget(DAT_ToTarget), .DAT_ToInitiator(DAT_ToInitiator),
    .ACK(ACK), .STALL(STALL), .LATCH_STB(LATCH_STB), .LATCH_D(LATCH_D)
  );

  always #5 CLK = ~CLK;

  // Reference model: clock state as plain integers, advanced one edge at a time.
  int m_s, m_m, m_h, m_day, m_halt, m_carry, m_presc, m_armed;
  int l_s, l_m, l_h, l_day, l_halt, l_carry;
  logic       exp_ack;
  logic [7:0] exp_dat;

  function automatic logic [7:0] view(input logic [2:0] a);
    logic [8:0] d;
    d = 9'(l_day);
    case (a)
      3'd0:    return {2'b11, 6'(l_s)};
      3'd1:    return {2'b11, 6'(l_m)};
      3'd2:    return {3'b111, 5'(l_h)};
      3'd3:    return d[7:0];
      3'd4:    return {l_carry != 0, l_halt != 0, 5'b11111, d[8]};
      default: return 8'hFF;
    endcase
  endfunction

  task automatic model_reset();
    m_s = 0; m_m = 0; m_h = 0; m_day = 0; m_halt = 0; m_carry = 0; m_presc = 0; m_armed = 0;
    l_s = 0; l_m = 0; l_h = 0; l_day = 0; l_halt = 0; l_carry = 0;
    exp_ack = 1'b0; exp_dat = 8'hFF;
  endtask

  task automatic model_step(input logic rst, input logic stb, input logic we, input logic [2:0] a,
                            input logic [7:0] d, input logic lstb, input logic ld);
    int  ns, nm, nh, nd, nhalt, ncarry;
    bit  tick, c_s, c_m, c_h;
    if (rst) begin
      model_reset();
      return;
    end
    tick    = (m_halt == 0) && (m_presc == P - 1);
    exp_ack = stb;
    if (stb && !we) exp_dat = view(a);
    if (lstb) begin
      if (!ld) m_armed = 1;
      else begin
        if (m_armed != 0) begin
          l_s = m_s; l_m = m_m; l_h = m_h; l_day = m_day; l_halt = m_halt; l_carry = m_carry;
        end
        m_armed = 0;
      end
    end
    ns = m_s; nm = m_m; nh = m_h; nd = m_day; nhalt = m_halt; ncarry = m_carry;
    if (tick) begin
      c_s = (m_s == 59);
      ns  = c_s ? 0 : (m_s + 1) % 64;
      c_m = c_s && (m_m == 59);
      if (c_s) nm = c_m ? 0 : (m_m + 1) % 64;
      c_h = c_m && (m_h == 23);
      if (c_m) nh = c_h ? 0 : (m_h + 1) % 32;
      if (c_h) begin
        nd = (m_day + 1) % 512;
        if (m_day == 511) ncarry = 1;
      end
    end
    if (stb && we) begin
      case (a)
        3'd0: ns = int'(d) % 64;
        3'd1: nm = int'(d) % 64;
        3'd2: nh = int'(d) % 32;
        3'd3: nd = (nd / 256) * 256 + int'(d);
        3'd4: begin
          ncarry = int'(d[7]);
          nhalt  = int'(d[6]);
          nd     = (nd % 256) + 256 * int'(d[0]);
        end
        default: ;
      endcase
    end
    if (stb && we && a == 3'd0) m_presc = 0;
    else if (m_halt == 0)       m_presc = tick ? 0 : m_presc + 1;
    m_s = ns; m_m = nm; m_h = nh; m_day = nd; m_halt = nhalt; m_carry = ncarry;
  endtask

  // One clock: apply inputs, step the model on the same edge, settle 1 time unit past the edge.
  task automatic drive(input logic stb, input logic we, input logic [2:0] a, input logic [7:0] d,
                       input logic lstb, input logic ld, input logic rst);
    STB = stb; WE = we; ADDR = a; DAT_ToTarget = d; LATCH_STB = lstb; LATCH_D = ld; RST = rst;
    @(posedge CLK);
    model_step(rst, stb, we, a, d, lstb, ld);
    #1;
    STB = 1'b0; WE = 1'b0; LATCH_STB = 1'b0; RST = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    drive(1'b1, 1'b1, a, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic latch_now();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] dat, output logic ack);
    drive(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0, 1'b0);
    dat = DAT_ToInitiator;
    ack = ACK;
  endtask

  task automatic test_reset();
    logic [7:0] dat;
    logic       ack;
    logic [7:0] want [5] = '{8'hC0, 8'hC0, 8'hE0, 8'h00, 8'h3E};
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ACK !== 1'b0 || DAT_ToInitiator !== 8'hFF || STALL !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs ack=%b dat=%h stall=%b want ack=0 dat=ff stall=0", ACK, DAT_ToInitiator, STALL);
    end
    for (int i = 0; i < 5; i++) begin
      read_reg(3'(i), dat, ack);
      checks++;
      if (ack !== 1'b1 || dat !== want[i] || dat !== exp_dat) begin
        errors++;
        $display("FAIL reset_read[%0d] ack=%b dat=%h want ack=1 dat=%h", i, ack, dat, want[i]);
      end
    end
    idle(1);
    checks++;
    if (ACK !== 1'b0 || DAT_ToInitiator !== 8'h3E) begin
      errors++;
      $display("FAIL ack_single_cycle ack=%b dat=%h want ack=0 dat=3e", ACK, DAT_ToInitiator);
    end
  endtask

  task automatic test_rollover();
    logic [7:0] dat;
    logic       ack;
    logic [7:0] want [5] = '{8'hC0, 8'hC0, 8'hE0, 8'h00, 8'hBE};
    write_reg(3'd0, 8'd59);
    write_reg(3'd1, 8'd59);
    write_reg(3'd2, 8'd23);
    write_reg(3'd3, 8'hFF);
    write_reg(3'd4, 8'h01);
    idle(64);
    latch_now();
    for (int i = 0; i < 5; i++) begin
      read_reg(3'(i), dat, ack);
      checks++;
      if (ack !== 1'b1 || dat !== want[i] || dat !== exp_dat) begin
        errors++;
        $display("FAIL rollover_read[%0d] ack=%b dat=%h want %h (model %h)", i, ack, dat, want[i], exp_dat);
      end
    end
  endtask

  task automatic test_halt();
    logic [7:0] dat;
    logic       ack;
    int         s_before;
    write_reg(3'd4, 8'h40);
    s_before = m_s;
    idle(1000);
    latch_now();
    read_reg(3'd0, dat, ack);
    checks++;
    if (dat !== {2'b11, 6'(s_before)} || dat !== exp_dat) begin
      errors++;
      $display("FAIL halt_hold dat=%h want %h", dat, {2'b11, 6'(s_before)});
    end
    write_reg(3'd4, 8'h00);
    idle(64);
    latch_now();
    read_reg(3'd0, dat, ack);
    checks++;
    if (dat !== {2'b11, 6'(s_before + 1)} || dat !== exp_dat) begin
      errors++;
      $display("FAIL halt_resume dat=%h want %h", dat, {2'b11, 6'(s_before + 1)});
    end
  endtask

  task automatic test_clamp();
    logic [7:0] dat;
    logic       ack;
    int         m_before;
    m_before = m_m;
    write_reg(3'd0, 8'd61);
    idle(130);
    latch_now();
    read_reg(3'd0, dat, ack);
    checks++;
    if (dat !== 8'hFF || dat !== exp_dat) begin
      errors++;
      $display("FAIL clamp_63 dat=%h want ff", dat);
    end
    idle(60);
    latch_now();
    read_reg(3'd0, dat, ack);
    checks++;
    if (dat !== 8'hC0 || dat !== exp_dat) begin
      errors++;
      $display("FAIL clamp_wrap dat=%h want c0", dat);
    end
    read_reg(3'd1, dat, ack);
    checks++;
    if (dat !== {2'b11, 6'(m_before)} || dat !== exp_dat) begin
      errors++;
      $display("FAIL clamp_no_carry dat=%h want %h", dat, {2'b11, 6'(m_before)});
    end
  endtask

  task automatic test_latch_seq();
    logic [7:0] dat;
    logic [7:0] old_view;
    logic       ack;
    old_view = view(3'd0);
    write_reg(3'd0, 8'd10);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0);
    read_reg(3'd0, dat, ack);
    checks++;
    if (dat !== old_view || dat !== exp_dat) begin
      errors++;
      $display("FAIL latch_unarmed dat=%h want %h", dat, old_view);
    end
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0);
    read_reg(3'd0, dat, ack);
    checks++;
    if (dat !== 8'hCA || dat !== exp_dat) begin
      errors++;
      $display("FAIL latch_sequence dat=%h want ca", dat);
    end
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'd0, 8'd5, 1'b1, 1'b1, 1'b0);
    read_reg(3'd0, dat, ack);
    checks++;
    if (dat !== 8'hCA || dat !== exp_dat) begin
      errors++;
      $display("FAIL latch_pre_write dat=%h want ca", dat);
    end
    latch_now();
    read_reg(3'd0, dat, ack);
    checks++;
    if (dat !== 8'hC5 || dat !== exp_dat) begin
      errors++;
      $display("FAIL latch_post_write dat=%h want c5", dat);
    end
  endtask

  task automatic test_write_tick();
    logic [7:0] dat;
    logic       ack;
    int         budget;
    budget = 0;
    while (m_presc != P - 1 && budget < 200) begin
      idle(1);
      budget++;
    end
    checks++;
    if (m_presc != P - 1) begin
      errors++;
      $display("FAIL write_tick_align budget expired presc=%0d want %0d", m_presc, P - 1);
    end
    write_reg(3'd0, 8'd20);
    idle(60);
    latch_now();
    read_reg(3'd0, dat, ack);
    checks++;
    if (dat !== 8'hD4 || dat !== exp_dat) begin
      errors++;
      $display("FAIL write_over_tick dat=%h want d4", dat);
    end
    idle(2);
    latch_now();
    read_reg(3'd0, dat, ack);
    checks++;
    if (dat !== 8'hD5 || dat !== exp_dat) begin
      errors++;
      $display("FAIL prescale_restart dat=%h want d5", dat);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] dat;
    logic       ack;
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ACK !== 1'b0 || DAT_ToInitiator !== 8'hFF) begin
      errors++;
      $display("FAIL reset_mid_ack ack=%b dat=%h want ack=0 dat=ff", ACK, DAT_ToInitiator);
    end
    latch_now();
    read_reg(3'd0, dat, ack);
    checks++;
    if (dat !== 8'hC0 || dat !== exp_dat) begin
      errors++;
      $display("FAIL reset_mid_state dat=%h want c0", dat);
    end
  endtask

  task automatic test_random();
    logic       stb, we, lstb, ld;
    logic [2:0] a;
    logic [7:0] d;
    for (int i = 0; i < 600; i++) begin
      stb  = ($urandom_range(0, 2) != 0);
      we   = $urandom_range(0, 1) != 0;
      a    = 3'($urandom_range(0, 7));
      d    = 8'($urandom);
      if (a == 3'd4 && $urandom_range(0, 3) != 0) d[6] = 1'b0;
      lstb = ($urandom_range(0, 3) == 0);
      ld   = $urandom_range(0, 1) != 0;
      drive(stb, we, a, d, lstb, ld, 1'b0);
      checks++;
      if (ACK !== exp_ack || DAT_ToInitiator !== exp_dat) begin
        errors++;
        $display("FAIL random[%0d] ack=%b dat=%h want ack=%b dat=%h", i, ACK, DAT_ToInitiator, exp_ack, exp_dat);
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    test_reset();
    test_rollover();
    test_halt();
    test_clamp();
    test_latch_seq();
    test_write_tick();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
